// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, op encoding, MUL/DIV
// sequencer states and the divide-by-zero quotient.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [WIDTH-1:0] DIVZ_QUOT = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_ITER,
    S_FIX_Q,
    S_FIX_R,
    S_DONE
  } state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mul_div_sequencer.sv
// Booth radix-2 multiply / restoring signed divide, time-sharing
// the ALU adder through add_x/add_y/add_sub and add_s.
module mul_div_sequencer
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_s
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q1_q, q1_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic             div_q, div_d;

  logic [WIDTH-1:0] y_eff;
  logic             ovf;
  logic             shin;
  logic             nb;

  // Adder drive depends on state registers only, never on add_s.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    unique case (state_q)
      S_NEG_A: begin
        add_y   = q_q;
        add_sub = 1'b1;
      end
      S_NEG_B: begin
        add_y   = m_q;
        add_sub = 1'b1;
      end
      S_ITER: begin
        if (div_q) begin
          add_x   = {a_q[MSB-1:0], q_q[MSB]};
          add_y   = m_q;
          add_sub = 1'b1;
        end else begin
          add_x = a_q;
          unique case ({q_q[0], q1_q})
            2'b01: add_y = m_q;
            2'b10: begin
              add_y   = m_q;
              add_sub = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_FIX_Q: begin
        add_y   = q_q;
        add_sub = 1'b1;
      end
      S_FIX_R: begin
        add_y   = a_q;
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  assign y_eff = add_sub ? ~add_y : add_y;
  assign ovf   = (add_x[MSB] == y_eff[MSB])
              && (add_s[MSB] != add_x[MSB]);
  assign shin  = add_s[MSB] ^ ovf;
  // Carry out of bit MSB: partial remainder >= |b|.
  assign nb    = maj3(add_x[MSB], y_eff[MSB],
                      add_s[MSB] ^ add_x[MSB] ^ y_eff[MSB]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    q1_d    = q1_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    div_d   = div_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = '0;
          q1_d  = 1'b0;
          cnt_d = '0;
          dz_d  = 1'b0;
          div_d = op;
          if (op == OP_MUL) begin
            q_d     = operand_b;
            m_d     = operand_a;
            state_d = S_ITER;
          end else if (operand_b == '0) begin
            hi_d    = operand_a;
            lo_d    = DIVZ_QUOT;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = operand_a;
            m_d     = operand_b;
            state_d = S_NEG_A;
          end
        end
      end
      S_NEG_A: begin
        sa_d    = q_q[MSB];
        q_d     = q_q[MSB] ? add_s : q_q;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        sb_d    = m_q[MSB];
        m_d     = m_q[MSB] ? add_s : m_q;
        state_d = S_ITER;
      end
      S_ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_q) begin
          a_d = nb ? add_s : add_x;
          q_d = {q_q[MSB-1:0], nb};
        end else begin
          a_d  = {shin, add_s[MSB:1]};
          q_d  = {add_s[0], q_q[MSB:1]};
          q1_d = q_q[0];
        end
        if (cnt_q == CNT_LAST) begin
          if (div_q) begin
            state_d = S_FIX_Q;
          end else begin
            hi_d    = a_d;
            lo_d    = q_d;
            state_d = S_DONE;
          end
        end
      end
      S_FIX_Q: begin
        lo_d    = (sa_q ^ sb_q) ? add_s : q_q;
        state_d = S_FIX_R;
      end
      S_FIX_R: begin
        hi_d    = sa_q ? add_s : a_q;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      q1_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      q1_q    <= q1_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench for mul_div_sequencer: closes the shared-adder loop and
// compares against 64-bit signed arithmetic.
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] add_x;
  logic [31:0] add_y;
  logic        add_sub;
  logic [31:0] add_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the ALU lookahead adder.
  assign add_s = add_x + (add_sub ? ~add_y : add_y) + {31'd0, add_sub};

  mul_div_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .add_x       (add_x),
    .add_y       (add_y),
    .add_sub     (add_sub),
    .add_s       (add_s)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic o,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] eh,
                                output logic [31:0] el,
                                output logic ed,
                                output int lat);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ed = 1'b0;
    if (o == 1'b0) begin
      r   = sa * sb;
      eh  = r[63:32];
      el  = r[31:0];
      lat = 33;
    end else if (b == 32'd0) begin
      eh  = a;
      el  = 32'hFFFF_FFFF;
      ed  = 1'b1;
      lat = 1;
    end else begin
      r   = sa / sb;
      el  = r[31:0];
      r   = sa % sb;
      eh  = r[31:0];
      lat = 37;
    end
  endfunction

  task automatic issue(input logic o, input logic [31:0] a,
                       input logic [31:0] b);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
  endtask

  // Called at the negedge where start is high; returns after done.
  task automatic finish(input logic o, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eh, el;
    logic        ed;
    int          elat, lat;
    bit          busy_ok;
    model(o, a, b, eh, el, ed, elat);
    @(negedge clk);
    start   = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      if (!busy) busy_ok = 1'b0;
      if (k == 1 && o == 1'b1 && b != 32'd0) begin
        chk("nega_y", {32'd0, add_y}, {32'd0, a});
        chk("nega_sub", {63'd0, add_sub}, 64'd1);
      end
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk("latency", 64'(lat), 64'(elat));
    chk("busy_during", {63'd0, busy_ok}, 64'd1);
    chk("hi", {32'd0, hi}, {32'd0, eh});
    chk("lo", {32'd0, lo}, {32'd0, el});
    chk("dbz", {63'd0, div_by_zero}, {63'd0, ed});
    @(negedge clk);
    chk("idle_after", {62'd0, busy, done}, 64'd0);
    chk("hold", {hi, lo}, {eh, el});
  endtask

  task automatic run_op(input logic o, input logic [31:0] a,
                        input logic [31:0] b);
    @(negedge clk);
    issue(o, a, b);
    finish(o, a, b);
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    op        = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {61'd0, busy, done, div_by_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_add", {add_x, add_y} | {63'd0, add_sub}, 64'd0);
    rst = 1'b0;

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 32'd5, 32'd0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'd0, 32'h1234_5678);
    run_op(1'b0, 32'h0001_2345, 32'hFFFF_0F0F);

    // Start ignored while busy, then reset mid-multiply.
    @(negedge clk);
    issue(1'b0, 32'd11, 32'd13);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b1, 32'd9, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", {62'd0, busy, done}, 64'd2);
    chk("ign_dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_add", {add_x, add_y} | {63'd0, add_sub}, 64'd0);
    issue(1'b0, 32'hFFFF_FFFE, 32'd6);
    finish(1'b0, 32'hFFFF_FFFE, 32'd6);

    for (int i = 0; i < 24; i++) begin
      logic        o;
      logic [31:0] a, b;
      o = 1'($urandom_range(1));
      a = pick();
      b = pick();
      run_op(o, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
